// File: rtl/alu_driver.sv
// Command-to-ALU sequencer: accepts one command, pulses the external ALU for a
// single cycle, holds the captured result until consumed and counts completions.
module alu_driver #(
    parameter  int unsigned n     = 8,
    localparam int unsigned cnt_w = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [n-1:0]     cmd_a,
    input  logic [n-1:0]     cmd_b,
    output logic [n-1:0]     alu_a,
    output logic [n-1:0]     alu_b,
    output logic [2:0]       alu_sel,
    output logic             alu_en,
    input  logic [n:0]       alu_q,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [n:0]       res_data,
    output logic [2:0]       res_op,
    output logic             res_err,
    output logic [cnt_w-1:0] op_count,
    output logic [cnt_w-1:0] err_count
);

    localparam logic [1:0] st_idle = 2'd0;
    localparam logic [1:0] st_exec = 2'd1;
    localparam logic [1:0] st_done = 2'd2;

    localparam logic [2:0] op_div = 3'b011;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       accept;
    logic       div_zero;
    logic       go_exec;
    logic       complete;

    // Next-state and handshake decode.
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        div_zero = 1'b0;
        go_exec  = 1'b0;
        complete = 1'b0;
        case (state_q)
            st_idle: begin
                if (cmd_valid) begin
                    accept   = 1'b1;
                    div_zero = (cmd_op == op_div) && (cmd_b == '0);
                    go_exec  = !div_zero;
                    state_d  = div_zero ? st_done : st_exec;
                end
            end
            st_exec: begin
                state_d = st_done;
            end
            st_done: begin
                if (res_ready) begin
                    complete = 1'b1;
                    state_d  = st_idle;
                end
            end
            default: begin
                state_d = st_idle;
            end
        endcase
    end

    // State, registered handshake/ALU drive, result capture and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= st_idle;
            cmd_ready <= 1'b1;
            res_valid <= 1'b0;
            alu_en    <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_sel   <= '0;
            res_data  <= '0;
            res_op    <= '0;
            res_err   <= 1'b0;
            op_count  <= '0;
            err_count <= '0;
        end else begin
            state_q   <= state_d;
            cmd_ready <= (state_d == st_idle);
            res_valid <= (state_d == st_done);
            alu_en    <= go_exec;

            // Operands are only presented to the ALU during the single EXEC cycle.
            if (go_exec) begin
                alu_a   <= cmd_a;
                alu_b   <= cmd_b;
                alu_sel <= cmd_op;
            end else begin
                alu_a   <= '0;
                alu_b   <= '0;
                alu_sel <= '0;
            end

            if (state_q == st_exec) begin
                res_data <= alu_q;
                res_op   <= alu_sel;
                res_err  <= 1'b0;
            end else if (accept && div_zero) begin
                res_data <= '0;
                res_op   <= cmd_op;
                res_err  <= 1'b1;
            end

            if (complete) begin
                op_count  <= op_count + cnt_w'(1);
                err_count <= err_count + cnt_w'(res_err);
            end
        end
    end

endmodule

// File: tb/tb_alu_driver.sv
// Bench for alu_driver: behavioural ALU plus transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_alu_driver;

    localparam int unsigned n = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [2:0]   cmd_op = 3'd0;
    logic [n-1:0] cmd_a = '0;
    logic [n-1:0] cmd_b = '0;
    logic [n-1:0] alu_a;
    logic [n-1:0] alu_b;
    logic [2:0]   alu_sel;
    logic         alu_en;
    logic [n:0]   alu_q;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [n:0]   res_data;
    logic [2:0]   res_op;
    logic         res_err;
    logic [15:0]  op_count;
    logic [15:0]  err_count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_driver #(.n(n)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_en(alu_en), .alu_q(alu_q),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_op(res_op), .res_err(res_err),
        .op_count(op_count), .err_count(err_count)
    );

    function automatic logic [8:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        logic [7:0]  t;
        p = 16'(a) * 16'(b);
        t = ~(a | b);
        case (op)
            3'd0:    return 9'(a) + 9'(b);
            3'd1:    return 9'(a) - 9'(b);
            3'd2:    return p[8:0];
            3'd3:    return (b == 8'd0) ? 9'd0 : {1'b0, 8'(a / b)};
            3'd4:    return {1'b0, a & b};
            3'd5:    return {1'b0, a | b};
            3'd6:    return {1'b0, a ^ b};
            default: return {1'b0, t};
        endcase
    endfunction

    // External ALU; a junk value when disabled exposes mistimed captures.
    always_comb alu_q = alu_en ? alu_ref(alu_sel, alu_a, alu_b) : 9'h1A5;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: one outstanding command, tracked by age in cycles since acceptance.
    bit         m_busy = 1'b0;
    bit         m_dz = 1'b0;
    int         m_age = 0;
    logic [7:0] m_a = '0;
    logic [7:0] m_b = '0;
    logic [2:0] m_op = '0;
    logic [15:0] m_ops = '0;
    logic [15:0] m_errs = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_age  = 0;
            m_ops  = '0;
            m_errs = '0;
        end else if (!m_busy) begin
            if (cmd_valid) begin
                m_busy = 1'b1;
                m_age  = 1;
                m_a    = cmd_a;
                m_b    = cmd_b;
                m_op   = cmd_op;
                m_dz   = (cmd_op == 3'b011) && (cmd_b == 8'd0);
            end
        end else if (m_age >= (m_dz ? 1 : 2) && res_ready) begin
            m_busy = 1'b0;
            m_ops  = m_ops + 16'd1;
            if (m_dz) m_errs = m_errs + 16'd1;
        end else if (m_age < 1000) begin
            m_age = m_age + 1;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            bit exp_exec;
            bit exp_done;
            exp_exec = m_busy && !m_dz && (m_age == 1);
            exp_done = m_busy && (m_age >= (m_dz ? 1 : 2));
            chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
            chk("alu_en", 32'(alu_en), 32'(exp_exec));
            chk("alu_a", 32'(alu_a), exp_exec ? 32'(m_a) : 32'd0);
            chk("alu_b", 32'(alu_b), exp_exec ? 32'(m_b) : 32'd0);
            chk("alu_sel", 32'(alu_sel), exp_exec ? 32'(m_op) : 32'd0);
            chk("res_valid", 32'(res_valid), 32'(exp_done));
            if (exp_done) begin
                chk("res_data", 32'(res_data), m_dz ? 32'd0 : 32'(alu_ref(m_op, m_a, m_b)));
                chk("res_op", 32'(res_op), 32'(m_op));
                chk("res_err", 32'(res_err), 32'(m_dz));
            end
            chk("op_count", 32'(op_count), 32'(m_ops));
            chk("err_count", 32'(err_count), 32'(m_errs));
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
    endtask

    initial begin
        logic [2:0] stream_ops [4];
        stream_ops[0] = 3'b000;
        stream_ops[1] = 3'b001;
        stream_ops[2] = 3'b110;
        stream_ops[3] = 3'b111;

        // Reset state
        repeat (2) cyc();
        chk_en = 1'b1;
        chk("rst cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst res_valid", 32'(res_valid), 32'd0);
        chk("rst alu_en", 32'(alu_en), 32'd0);
        chk("rst res_data", 32'(res_data), 32'd0);
        chk("rst op_count", 32'(op_count), 32'd0);
        rst = 1'b0;

        // Add 200 + 100 with the consumer always ready
        res_ready = 1'b1;
        send(3'b000, 8'd200, 8'd100);
        cyc();
        cmd_valid = 1'b0;
        chk("add alu_en", 32'(alu_en), 32'd1);
        chk("add alu_sel", 32'(alu_sel), 32'd0);
        cyc();
        chk("add res_valid", 32'(res_valid), 32'd1);
        chk("add res_data", 32'(res_data), 32'd300);
        chk("add res_err", 32'(res_err), 32'd0);
        cyc();
        chk("add op_count", 32'(op_count), 32'd1);

        // Divide by zero completes without touching the ALU
        send(3'b011, 8'd50, 8'd0);
        cyc();
        cmd_valid = 1'b0;
        chk("dz res_valid", 32'(res_valid), 32'd1);
        chk("dz alu_en", 32'(alu_en), 32'd0);
        chk("dz res_data", 32'(res_data), 32'd0);
        chk("dz res_err", 32'(res_err), 32'd1);
        cyc();
        chk("dz err_count", 32'(err_count), 32'd1);
        chk("dz op_count", 32'(op_count), 32'd2);

        // Backpressure on an AND result
        res_ready = 1'b0;
        send(3'b100, 8'hF0, 8'h3C);
        cyc();
        cmd_valid = 1'b1;
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk("bp res_valid", 32'(res_valid), 32'd1);
            chk("bp res_data", 32'(res_data), 32'h030);
            chk("bp cmd_ready", 32'(cmd_ready), 32'd0);
            cyc();
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        cyc();
        chk("bp release", 32'(res_valid), 32'd0);
        chk("bp op_count", 32'(op_count), 32'd3);

        // Reset during EXEC discards the operation
        send(3'b000, 8'd1, 8'd2);
        cyc();
        chk("abort alu_en", 32'(alu_en), 32'd1);
        cmd_valid = 1'b0;
        rst = 1'b1;
        cyc();
        chk("abort res_valid", 32'(res_valid), 32'd0);
        chk("abort cmd_ready", 32'(cmd_ready), 32'd1);
        chk("abort op_count", 32'(op_count), 32'd0);
        rst = 1'b0;
        cyc();

        // Streaming: one acceptance every third cycle
        for (int k = 0; k < 4; k++) begin
            send(stream_ops[k], 8'($urandom), 8'($urandom));
            cyc();
            if (k == 3) cmd_valid = 1'b0;
            cyc();
            cyc();
            chk("stream cmd_ready", 32'(cmd_ready), 32'd1);
            chk("stream op_count", 32'(op_count), 32'(k + 1));
        end

        // Counter wrap from a preloaded all-ones value
        m_ops  = 16'hFFFF;
        m_errs = 16'hFFFF;
        force dut.op_count = 16'hFFFF;
        force dut.err_count = 16'hFFFF;
        cyc();
        release dut.op_count;
        release dut.err_count;
        send(3'b011, 8'd9, 8'd0);
        cyc();
        cmd_valid = 1'b0;
        cyc();
        chk("wrap op_count", 32'(op_count), 32'd0);
        chk("wrap err_count", 32'(err_count), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            cmd_valid = ($urandom_range(0, 9) < 7);
            cmd_op    = 3'($urandom_range(0, 7));
            cmd_a     = 8'($urandom);
            cmd_b     = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            res_ready = ($urandom_range(0, 9) < 6);
            cyc();
        end
        rst       = 1'b0;
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        repeat (4) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_driver.md
ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 SHALL have parameter n, default 8: operand width in bits.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port cmd_valid, input, 1: command present.
REQ-005 SHALL have port cmd_ready, output, 1: driver can accept a command.
REQ-006 SHALL have port cmd_op, input, 3: ALU operation code.
- 000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 xor, 111 nor.
REQ-007 SHALL have ports cmd_a and cmd_b, input, n each: operands.
REQ-008 SHALL have ports alu_a and alu_b, output, n each: operands driven to the ALU.
REQ-009 SHALL have port alu_sel, output, 3: operation select driven to the ALU.
REQ-010 SHALL have port alu_en, output, 1: ALU enable.
REQ-011 SHALL have port alu_q, input, n+1: combinational ALU result.
REQ-012 SHALL have port res_valid, output, 1: result available.
REQ-013 SHALL have port res_ready, input, 1: consumer accepts result.
REQ-014 SHALL have port res_data, output, n+1: captured result.
REQ-015 SHALL have port res_op, output, 3: opcode of the held result.
REQ-016 SHALL have port res_err, output, 1: divide-by-zero flag for the held result.
REQ-017 SHALL have ports op_count and err_count, output, 16 each: completed-result and error counters.

Function
REQ-018 SHALL implement FSM states IDLE, EXEC, DONE; no other reachable states.
REQ-019 cmd_ready SHALL equal 1 only in IDLE.
REQ-020 SHALL accept a command on a cycle with IDLE and cmd_valid=1.
- Acceptance latches cmd_op, cmd_a, cmd_b into internal registers.
REQ-021 After acceptance of a command that is not a divide by zero, the FSM SHALL go IDLE->EXEC.
REQ-022 A command with cmd_op=011 and cmd_b=0 SHALL go IDLE->DONE directly.
- alu_en is never asserted for it; res_data=0, res_err=1.
REQ-023 In EXEC, for exactly one cycle, the driver SHALL drive:
- alu_en=1;
- alu_a, alu_b, alu_sel from the latched registers.
REQ-024 At the end of EXEC, alu_q SHALL be registered into res_data (all n+1 bits) with res_err=0; FSM -> DONE.
REQ-025 Outside EXEC, alu_en SHALL be 0; alu_a, alu_b and alu_sel SHALL be 0.
REQ-026 In DONE, res_valid=1, and res_data, res_op and res_err SHALL stay stable until the cycle res_ready=1.
REQ-027 On the DONE cycle with res_ready=1, the FSM SHALL return to IDLE.
REQ-028 On that same cycle, op_count SHALL increment by 1; err_count SHALL increment by 1 if res_err=1.
REQ-029 Both counters SHALL wrap from 16'hFFFF to 0.
REQ-030 Latency SHALL be fixed:
- normal op: res_valid first high 2 cycles after the acceptance edge;
- divide by zero: 1 cycle after it.
REQ-031 Back-to-back throughput SHALL be one command per 3 cycles with res_ready held at 1; no command is accepted while DONE.
REQ-032 cmd_valid while not IDLE SHALL be ignored; the command is not lost, because cmd_ready=0.
REQ-033 res_ready while not DONE SHALL have no effect.

Reset
REQ-034 With rst=1 at a rising edge, the next state SHALL be IDLE.
- Also: op_count=0, err_count=0, res_data=0, res_op=0, res_err=0, latched operands=0.
REQ-035 During and after reset: res_valid=0, alu_en=0, cmd_ready=1.
REQ-036 Reset asserted in EXEC or DONE SHALL abort the operation; the in-flight result is discarded and not counted.
REQ-037 rst SHALL take priority over all handshakes on the same edge.

Verification
REQ-038 Add: n=8, op=000, a=8'd200, b=8'd100, res_ready=1 ->
- alu_en high one cycle, alu_sel=000;
- res_data=9'd300 captured from alu_q; res_err=0; op_count=1.
REQ-039 Divide by zero: op=011, a=8'd50, b=0 ->
- alu_en never high; res_valid 1 cycle after accept;
- res_data=0, res_err=1; err_count=1 after res_ready.
REQ-040 Backpressure: op=100, a=8'hF0, b=8'h3C, res_ready=0 for 5 cycles ->
- res_valid held, res_data=9'h030 stable, cmd_ready=0;
- completes on the first res_ready=1 cycle.
REQ-041 Reset mid-operation: assert rst in the EXEC cycle ->
- next cycle IDLE, res_valid=0, op_count unchanged at 0.
REQ-042 Streaming: 4 commands (add, sub, xor, nor) with cmd_valid and res_ready held 1 ->
- accepted every 3rd cycle; results in order; op_count=4.
REQ-043 Counter wrap: preload op_count to 16'hFFFF through a sequence, complete one op -> op_count=0.
